falling_object_ctrl: RTL

// Per-object motion controller for pushable/falling playfield items (gold bags, boulders).
// One instance per object, with all timing and geometry set by parameters.

---
 rtl/falling_object_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/falling_object_ctrl.sv
// falling_object_ctrl: push/wobble/fall/crash motion of one playfield object, stepped once per frame.
// Optional gravity acceleration enabled by defining FALL_ACCEL_EN.
module falling_object_ctrl #(
  parameter int INITIAL_X         = 32,
  parameter int INITIAL_Y         = 160,
  parameter int CELL_LOG2         = 5,
  parameter int FP_SHIFT          = 6,
  parameter int X_SPEED           = 128,
  parameter int Y_SPEED_INIT      = 128,
  parameter int Y_ACCEL           = 16,
  parameter int Y_SPEED_MAX       = 400,
  parameter int WOBBLE_FRAMES     = 130,
  parameter int CRASH_FALL_FRAMES = 18
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               can_fall,
  input  logic [1:0]         can_push,
  input  logic               collision,
  input  logic               side,
  input  logic               been_eaten,
  output logic [1:0]         obj_state,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         image,
  output logic               busy
);
  localparam int CB = CELL_LOG2 + FP_SHIFT;
  localparam logic signed [31:0] X0 = 32'(INITIAL_X * (1 << FP_SHIFT));
  localparam logic signed [31:0] Y0 = 32'(INITIAL_Y * (1 << FP_SHIFT));
  localparam logic signed [31:0] XS = 32'(X_SPEED);
  localparam logic [15:0] WF = 16'(WOBBLE_FRAMES);
  localparam logic [9:0]  CF = 10'(CRASH_FALL_FRAMES);
  localparam logic [15:0] YSI = 16'(Y_SPEED_INIT);
  typedef enum logic [2:0] {IDLE, PUSH_R, PUSH_L, WOBBLE, FALL, CRASHED, EATEN} state_t;
  state_t state_q, state_d;
  logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d, ny;
  logic [15:0] yspeed_q, yspeed_d, wcnt_q, wcnt_d;
  logic [9:0] fcnt_q, fcnt_d;
  logic hit_q, hit_d, side_q, side_d, hit, s;
  logic [1:0] obj_state_q, obj_state_d, image_q, image_d;
  logic busy_q, busy_d;
`ifdef FALL_ACCEL_EN
  logic [16:0] ysum;
  assign ysum = {1'b0, yspeed_q} + 17'(Y_ACCEL);
`else
  logic unused_cfg;
  assign unused_cfg = ^{Y_ACCEL, Y_SPEED_MAX};
`endif
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    yspeed_d = yspeed_q;
    wcnt_d = wcnt_q;
    fcnt_d = fcnt_q;
    hit = hit_q | collision;
    s = collision ? side : side_q;
    hit_d = hit & ~startOfFrame;
    side_d = s;
    ny = pos_y_q + $signed({16'b0, yspeed_q});
    if (startOfFrame) begin
      case (state_q)
        IDLE: begin
          if (hit && can_push[~s]) state_d = s ? PUSH_L : PUSH_R;
          else if (can_fall) begin
            state_d = WOBBLE;
            wcnt_d = '0;
          end
        end
        PUSH_R, PUSH_L: begin
          pos_x_d = (state_q == PUSH_R) ? pos_x_q + XS : pos_x_q - XS;
          if (pos_x_d[CB-1:0] == '0) state_d = IDLE;
        end
        WOBBLE: begin
          wcnt_d = wcnt_q + 16'd1;
          if (!can_fall) state_d = IDLE;
          else if (wcnt_d == WF) begin
            state_d = FALL;
            yspeed_d = YSI;
            fcnt_d = '0;
          end
        end
        FALL: begin
          fcnt_d = fcnt_q + 10'(fcnt_q != 10'd1023);
          pos_y_d = ny;
`ifdef FALL_ACCEL_EN
          yspeed_d = (ysum > 17'(Y_SPEED_MAX)) ? 16'(Y_SPEED_MAX) : ysum[15:0];
`endif
          // land only where the step reaches or crosses a cell boundary
          if (!can_fall && (ny[31:CB] != pos_y_q[31:CB] || ny[CB-1:0] == '0)) begin
            pos_y_d = {ny[31:CB], {CB{1'b0}}};
            state_d = (fcnt_d >= CF) ? CRASHED : IDLE;
          end
        end
        CRASHED: state_d = been_eaten ? EATEN : CRASHED;
        default: state_d = state_q;
      endcase
    end
    obj_state_d = (state_d == FALL) ? 2'd1 : (state_d == CRASHED) ? 2'd2 : (state_d == EATEN) ? 2'd3 : 2'd0;
    image_d = (state_d == CRASHED || state_d == EATEN) ? 2'd3 :
              (state_d != WOBBLE) ? 2'd0 :
              (wcnt_d[5:4] == 2'd1) ? 2'd1 : (wcnt_d[5:4] == 2'd3) ? 2'd2 : 2'd0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      pos_x_q <= X0;
      pos_y_q <= Y0;
      yspeed_q <= '0;
      wcnt_q <= '0;
      fcnt_q <= '0;
      hit_q <= 1'b0;
      side_q <= 1'b0;
      obj_state_q <= '0;
      image_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      yspeed_q <= yspeed_d;
      wcnt_q <= wcnt_d;
      fcnt_q <= fcnt_d;
      hit_q <= hit_d;
      side_q <= side_d;
      obj_state_q <= obj_state_d;
      image_q <= image_d;
      busy_q <= busy_d;
    end
  end
  assign topLeftX = pos_x_q[FP_SHIFT+10:FP_SHIFT];
  assign topLeftY = pos_y_q[FP_SHIFT+10:FP_SHIFT];
  assign obj_state = obj_state_q;
  assign image = image_q;
  assign busy = busy_q;
endmodule
